mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mips_pkg.sv | 48 ++++
 rtl/mc_idec.sv | 40 ++++
 rtl/mc_ctrl.sv | 154 +++++++++++++++
 tb/tb_mc_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, funcs, FSM
// state codes, datapath select encodings and instruction-class indices.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [1:0] NPC_PC4 = 2'd0, NPC_BR = 2'd1, NPC_J = 2'd2, NPC_JR = 2'd3;
  localparam logic [1:0] DST_RT  = 2'd0, DST_RD = 2'd1, DST_RA = 2'd2;
  localparam logic [1:0] SRC_ALU = 2'd0, SRC_MEM = 2'd1, SRC_PC = 2'd2;
  localparam logic [1:0] ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_OR = 2'd2;
  localparam logic [1:0] EXT_ZERO = 2'd0, EXT_SIGN = 2'd1, EXT_HI = 2'd2;

  // One-hot instruction class bit positions
  localparam int C_ADDU = 0;
  localparam int C_SUBU = 1;
  localparam int C_JR   = 2;
  localparam int C_ORI  = 3;
  localparam int C_LUI  = 4;
  localparam int C_LW   = 5;
  localparam int C_SW   = 6;
  localparam int C_BEQ  = 7;
  localparam int C_J    = 8;
  localparam int C_JAL  = 9;
  localparam int C_NOP  = 10;
  localparam int C_NUM  = 11;

  typedef logic [C_NUM-1:0] icls_t;

endpackage

// File: rtl/mc_idec.sv
// Instruction classifier: maps the IR word to a one-hot class; anything not
// recognised lands in the nop class.
module mc_idec
  import mips_pkg::*;
(
  input  logic [31:0] i_instr,
  output icls_t       o_cls
);

  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic       w_unused;

  assign w_op     = i_instr[31:26];
  assign w_fn     = i_instr[5:0];
  assign w_unused = ^i_instr[25:6];

  always_comb begin
    o_cls = '0;
    case (w_op)
      OP_RTYPE: begin
        case (w_fn)
          FN_ADDU: o_cls[C_ADDU] = 1'b1;
          FN_SUBU: o_cls[C_SUBU] = 1'b1;
          FN_JR:   o_cls[C_JR]   = 1'b1;
          default: o_cls[C_NOP]  = 1'b1;
        endcase
      end
      OP_ORI:  o_cls[C_ORI] = 1'b1;
      OP_LUI:  o_cls[C_LUI] = 1'b1;
      OP_LW:   o_cls[C_LW]  = 1'b1;
      OP_SW:   o_cls[C_SW]  = 1'b1;
      OP_BEQ:  o_cls[C_BEQ] = 1'b1;
      OP_J:    o_cls[C_J]   = 1'b1;
      OP_JAL:  o_cls[C_JAL] = 1'b1;
      default: o_cls[C_NOP] = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM. Only state and the retired-instruction counter
// are registered; every control output is decoded combinationally.
module mc_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             pc_we,
  output logic             ir_we,
  output logic             mem_we,
  output logic             rf_we,
  output logic [1:0]       npc_sel,
  output logic [1:0]       rf_dst,
  output logic [1:0]       rf_src,
  output logic [1:0]       alu_op,
  output logic             alu_srcb,
  output logic [1:0]       ext_op,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic [CNT_W-1:0] instret
);

  state_t           r_state, w_next;
  icls_t            w_cls;
  logic [CNT_W-1:0] r_instret;
  logic             w_req, w_pc, w_ir, w_mw, w_rf, w_done;
  logic             w_jump;

  mc_idec u_idec (.i_instr(instr), .o_cls(w_cls));

  assign w_jump = w_cls[C_J] | w_cls[C_JAL] | w_cls[C_JR];

  // Selects depend on the class alone, so they stay put from EXEC through WB.
  always_comb begin
    rf_dst   = DST_RT;
    rf_src   = SRC_ALU;
    alu_op   = ALU_ADD;
    alu_srcb = 1'b0;
    ext_op   = EXT_ZERO;
    if (w_cls[C_ADDU]) begin
      rf_dst = DST_RD;
    end else if (w_cls[C_SUBU]) begin
      rf_dst = DST_RD;
      alu_op = ALU_SUB;
    end else if (w_cls[C_ORI] | w_cls[C_LUI]) begin
      alu_op   = ALU_OR;
      alu_srcb = 1'b1;
      ext_op   = w_cls[C_LUI] ? EXT_HI : EXT_ZERO;
    end else if (w_cls[C_LW] | w_cls[C_SW]) begin
      alu_srcb = 1'b1;
      ext_op   = EXT_SIGN;
      rf_src   = w_cls[C_LW] ? SRC_MEM : SRC_ALU;
    end else if (w_cls[C_BEQ]) begin
      alu_op = ALU_SUB;
    end else if (w_cls[C_JAL]) begin
      rf_dst = DST_RA;
      rf_src = SRC_PC;
    end
  end

  always_comb begin
    npc_sel = NPC_PC4;
    if (r_state != S_FETCH) begin
      if (w_cls[C_J] | w_cls[C_JAL]) npc_sel = NPC_J;
      else if (w_cls[C_JR])          npc_sel = NPC_JR;
      else if (w_cls[C_BEQ])         npc_sel = NPC_BR;
    end
  end

  always_comb begin
    w_next = r_state;
    w_req  = 1'b0;
    w_pc   = 1'b0;
    w_ir   = 1'b0;
    w_mw   = 1'b0;
    w_rf   = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_req = 1'b1;
        if (mem_ready) begin
          w_ir   = 1'b1;
          w_pc   = 1'b1;
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_jump) begin
          w_pc   = 1'b1;
          w_rf   = w_cls[C_JAL];
          w_done = 1'b1;
          w_next = S_FETCH;
        end else if (w_cls[C_NOP]) begin
          w_done = 1'b1;
          w_next = S_FETCH;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_cls[C_BEQ]) begin
          w_pc   = zero;
          w_done = 1'b1;
          w_next = S_FETCH;
        end else if (w_cls[C_LW] | w_cls[C_SW]) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        w_req = 1'b1;
        w_mw  = w_cls[C_SW];
        if (mem_ready) begin
          w_done = w_cls[C_SW];
          w_next = w_cls[C_SW] ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        w_rf   = 1'b1;
        w_done = 1'b1;
        w_next = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Reset must silence the FETCH request/enables even though state is FETCH.
  assign mem_req    = w_req  & ~reset;
  assign pc_we      = w_pc   & ~reset;
  assign ir_we      = w_ir   & ~reset;
  assign mem_we     = w_mw   & ~reset;
  assign rf_we      = w_rf   & ~reset;
  assign instr_done = w_done & ~reset;
  assign state      = r_state;
  assign instret    = r_instret;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_done) r_instret <= r_instret + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: per-instruction phase model with random
// memory stalls, checked cycle by cycle; narrow counter exercises wrap.
module tb_mc_ctrl;

  localparam int CW = 4;

  localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_ORI = 3, K_LUI = 4, K_LW = 5;
  localparam int K_SW = 6, K_BEQ = 7, K_J = 8, K_JAL = 9, K_NOP = 10;

  logic          clk = 1'b0;
  logic          reset, zero, mem_ready;
  logic [31:0]   instr;
  logic          mem_req, pc_we, ir_we, mem_we, rf_we, alu_srcb, instr_done;
  logic [1:0]    npc_sel, rf_dst, rf_src, alu_op, ext_op;
  logic [2:0]    state;
  logic [CW-1:0] instret;

  int n_chk = 0;
  int n_err = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  mc_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .pc_we(pc_we), .ir_we(ir_we), .mem_we(mem_we), .rf_we(rf_we),
    .npc_sel(npc_sel), .rf_dst(rf_dst), .rf_src(rf_src), .alu_op(alu_op),
    .alu_srcb(alu_srcb), .ext_op(ext_op), .state(state), .instr_done(instr_done),
    .instret(instret)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ectl = {mem_req, pc_we, ir_we, mem_we, rf_we, instr_done}
  task automatic look(input string tag, input logic [2:0] est, input logic [5:0] ectl);
    @(negedge clk);
    chk({tag, ".state"}, 32'(state), 32'(est));
    chk({tag, ".ctl"}, 32'({mem_req, pc_we, ir_we, mem_we, rf_we, instr_done}), 32'(ectl));
  endtask

  task automatic retire();
    exp_ret = (exp_ret + 1) % (1 << CW);
    chk("instret", 32'(instret), exp_ret);
  endtask

  function automatic logic [31:0] enc(input int k);
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] idx;
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
    imm = 16'($urandom); idx = 26'($urandom);
    case (k)
      K_ADDU:  return {6'h00, rs, rt, rd, 5'd0, 6'h21};
      K_SUBU:  return {6'h00, rs, rt, rd, 5'd0, 6'h23};
      K_JR:    return {6'h00, rs, 15'd0, 6'h08};
      K_ORI:   return {6'h0D, rs, rt, imm};
      K_LUI:   return {6'h0F, 5'd0, rt, imm};
      K_LW:    return {6'h23, rs, rt, imm};
      K_SW:    return {6'h2B, rs, rt, imm};
      K_BEQ:   return {6'h04, rs, rt, imm};
      K_J:     return {6'h02, idx};
      K_JAL:   return {6'h03, idx};
      default: begin
        case ($urandom_range(3))
          0:       return 32'h0000_0000;
          1:       return 32'hFC00_0000;
          2:       return {6'h00, rs, rt, rd, 5'd0, 6'h20};
          default: return {6'h08, rs, rt, imm};
        endcase
      end
    endcase
  endfunction

  // One instruction: fst FETCH stalls, mst MEM stalls, z = ALU equal flag.
  task automatic run(input int k, input logic [31:0] ins, input int fst, input int mst, input logic z);
    logic is_sw;
    is_sw = (k == K_SW);
    instr = ins;
    zero  = z;
    for (int i = 0; i <= fst; i++) begin
      mem_ready = (i == fst);
      if (i < fst) look("fetch_wait", 3'd0, 6'b100000);
      else begin
        look("fetch", 3'd0, 6'b111000);
        chk("fetch.npc", 32'(npc_sel), 0);
      end
      tick();
    end

    mem_ready = 1'($urandom);
    case (k)
      K_J: begin
        look("dec_j", 3'd1, 6'b010001);
        chk("dec_j.npc", 32'(npc_sel), 2);
      end
      K_JAL: begin
        look("dec_jal", 3'd1, 6'b010011);
        chk("dec_jal.sel", 32'({npc_sel, rf_dst, rf_src}), 32'({2'd2, 2'd2, 2'd2}));
      end
      K_JR: begin
        look("dec_jr", 3'd1, 6'b010001);
        chk("dec_jr.npc", 32'(npc_sel), 3);
      end
      K_NOP:   look("dec_nop", 3'd1, 6'b000001);
      default: look("dec", 3'd1, 6'b000000);
    endcase
    tick();
    if (k == K_J || k == K_JAL || k == K_JR || k == K_NOP) begin
      retire();
      return;
    end

    mem_ready = 1'($urandom);
    if (k == K_BEQ) begin
      look("exec_beq", 3'd2, {1'b0, z, 4'b0001});
      chk("exec_beq.sel", 32'({npc_sel, alu_op, alu_srcb}), 32'({2'd1, 2'd1, 1'b0}));
      tick();
      retire();
      return;
    end
    look("exec", 3'd2, 6'b000000);
    if (k == K_LW || is_sw)
      chk("exec_ls.alu", 32'({alu_op, alu_srcb, ext_op}), 32'({2'd0, 1'b1, 2'd1}));
    tick();

    if (k == K_LW || is_sw) begin
      for (int i = 0; i <= mst; i++) begin
        mem_ready = (i == mst);
        look(i < mst ? "mem_wait" : "mem", 3'd3,
             {1'b1, 1'b0, 1'b0, is_sw, 1'b0, is_sw && (i == mst)});
        chk("mem.alu", 32'({alu_op, alu_srcb, ext_op}), 32'({2'd0, 1'b1, 2'd1}));
        tick();
      end
      if (is_sw) begin
        retire();
        return;
      end
    end

    mem_ready = 1'($urandom);
    look("wb", 3'd4, 6'b000011);
    case (k)
      K_ADDU: chk("wb_addu.sel", 32'({rf_dst, rf_src, alu_op, alu_srcb}), 32'({2'd1, 2'd0, 2'd0, 1'b0}));
      K_SUBU: chk("wb_subu.sel", 32'({rf_dst, rf_src, alu_op, alu_srcb}), 32'({2'd1, 2'd0, 2'd1, 1'b0}));
      K_ORI:  chk("wb_ori.sel", 32'({rf_dst, rf_src, alu_op, alu_srcb, ext_op}),
                  32'({2'd0, 2'd0, 2'd2, 1'b1, 2'd0}));
      K_LUI:  chk("wb_lui.sel", 32'({rf_dst, rf_src, alu_op, alu_srcb, ext_op}),
                  32'({2'd0, 2'd0, 2'd2, 1'b1, 2'd2}));
      default: chk("wb_lw.sel", 32'({rf_dst, rf_src, alu_op, alu_srcb, ext_op}),
                   32'({2'd0, 2'd1, 2'd0, 1'b1, 2'd1}));
    endcase
    tick();
    retire();
  endtask

  initial begin
    reset = 1'b1; zero = 1'b0; mem_ready = 1'b1; instr = 32'h0;
    tick(); tick();
    look("rst", 3'd0, 6'b000000);
    chk("rst.instret", 32'(instret), 0);
    tick();
    reset = 1'b0;

    run(K_ORI, 32'h3401_3456, 0, 0, 1'b0);
    run(K_LW,  32'h8C22_0004, 0, 3, 1'b0);
    run(K_BEQ, 32'h1022_0003, 0, 0, 1'b1);
    run(K_BEQ, 32'h1022_0003, 0, 0, 1'b0);
    run(K_JAL, 32'h0C00_0100, 0, 0, 1'b0);
    run(K_NOP, 32'hFC00_0000, 0, 0, 1'b0);
    run(K_NOP, 32'h0000_0000, 1, 0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      int k;
      k = $urandom_range(10);
      run(k, enc(k), $urandom_range(2), $urandom_range(2), 1'($urandom));
    end

    // Reset landing in the WB of an lw: abandoned, not counted.
    instr = 32'h8C22_0004; mem_ready = 1'b1;
    tick(); tick(); tick(); tick();
    look("pre_rst_wb", 3'd4, 6'b000011);
    reset = 1'b1;
    tick();
    look("rst_wb", 3'd0, 6'b000000);
    chk("rst_wb.instret", 32'(instret), 0);
    exp_ret = 0;
    tick();
    reset = 1'b0;
    run(K_ADDU, enc(K_ADDU), 0, 0, 1'b0);
    run(K_SW, enc(K_SW), 2, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
